// File: rtl/iter_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : iter_shift_unit
// Description : Multi-cycle shifter (SLL/SRL/SRA/ROTR), at most STEP bits per
//               cycle, with a start/busy/done handshake for EX-stage stalling.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_shift_unit #(
    parameter int WIDTH = 32,
    parameter int SA_W  = 5,
    parameter int STEP  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_flush,
    input  logic [1:0]       i_OpShift,
    input  logic [SA_W-1:0]  i_SA,
    input  logic [WIDTH-1:0] i_B,
    output logic [WIDTH-1:0] o_ShiftRes,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [SA_W-1:0] c_STEP = SA_W'(STEP);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_res;
    logic [SA_W-1:0]  r_cnt;
    logic [1:0]       r_op;

    logic [SA_W-1:0]  w_n;
    logic [SA_W-1:0]  w_cntNext;
    logic [WIDTH-1:0] w_accNext;

    always_comb begin
        w_n       = (r_cnt < c_STEP) ? r_cnt : c_STEP;
        w_cntNext = r_cnt - w_n;
        w_accNext = r_acc;
        case (r_op)
            2'd0:    w_accNext = r_acc << w_n;
            2'd1:    w_accNext = r_acc >> w_n;
            // Arithmetic shift keeps acc[WIDTH-1] fixed, so the sign survives every step.
            2'd2:    w_accNext = $unsigned($signed(r_acc) >>> w_n);
            default: w_accNext = WIDTH'({r_acc, r_acc} >> w_n);
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_IDLE;
            r_acc   <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (i_flush) begin
                        r_state <= c_IDLE;
                    end else if (i_start) begin
                        r_acc <= i_B;
                        r_op  <= i_OpShift;
                        r_cnt <= i_SA;
                        if (i_SA == '0) begin
                            r_state <= c_DONE;
                            r_res   <= i_B;
                        end else begin
                            r_state <= c_SHIFT;
                        end
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_SHIFT: begin
                    // Flush abandons the partial result; r_res keeps the last completed one.
                    if (i_flush) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_acc <= w_accNext;
                        r_cnt <= w_cntNext;
                        if (w_cntNext == '0) begin
                            r_state <= c_DONE;
                            r_res   <= w_accNext;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign o_ShiftRes = r_res;
    assign o_busy     = (r_state == c_SHIFT);
    assign o_done     = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_iter_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_shift_unit
// Description : Directed self-checking bench for iter_shift_unit (STEP=1 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_shift_unit;

    logic        clk;
    logic        rstN;
    logic        start;
    logic        flush;
    logic [1:0]  opShift;
    logic [4:0]  sa;
    logic [31:0] b;
    logic [31:0] res1, res4;
    logic        busy1, busy4, done1, done4;

    int checks = 0;
    int errors = 0;

    iter_shift_unit #(.WIDTH(32), .SA_W(5), .STEP(1)) dut (
        .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_flush(flush),
        .i_OpShift(opShift), .i_SA(sa), .i_B(b),
        .o_ShiftRes(res1), .o_busy(busy1), .o_done(done1)
    );

    iter_shift_unit #(.WIDTH(32), .SA_W(5), .STEP(4)) dut4 (
        .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_flush(flush),
        .i_OpShift(opShift), .i_SA(sa), .i_B(b),
        .o_ShiftRes(res4), .o_busy(busy4), .o_done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lets both instances return to IDLE so the next start is accepted by each.
    task automatic settle();
        for (int k = 0; k < 64; k++) begin
            if (!busy1 && !busy4 && !done1 && !done4) break;
            step();
        end
    endtask

    // Issues one start and reports latency (edges from accept to done), busy cycles and result.
    task automatic runOp(input logic sel, input logic [1:0] op, input logic [4:0] amt,
                         input logic [31:0] val, output int lat, output int busyCnt,
                         output logic [31:0] res);
        opShift = op; sa = amt; b = val; start = 1'b1;
        step();
        start = 1'b0;
        lat = -1;
        busyCnt = 0;
        for (int k = 1; k <= 100; k++) begin
            if (sel ? busy4 : busy1) busyCnt++;
            if (sel ? done4 : done1) begin
                lat = k;
                break;
            end
            step();
        end
        res = sel ? res4 : res1;
    endtask

    task automatic test_reset();
        checks++; if (res1 !== 32'h0) begin errors++; $display("FAIL reset_res1: got %h want %h", res1, 32'h0); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b want 0", busy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done1: got %b want 0", done1); end
        checks++; if (res4 !== 32'h0) begin errors++; $display("FAIL reset_res4: got %h want %h", res4, 32'h0); end
        checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            errors++; $display("FAIL reset_hs4: got busy=%b done=%b want 0 0", busy4, done4);
        end
    endtask

    task automatic test_sll();
        int lat, bc;
        logic [31:0] r;
        runOp(1'b0, 2'd0, 5'd31, 32'h0000_0001, lat, bc, r);
        checks++; if (lat !== 32) begin errors++; $display("FAIL sll31_latency: got %0d want 32", lat); end
        checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL sll31_res: got %h want 80000000", r); end
        checks++; if (bc !== 31) begin errors++; $display("FAIL sll31_busy_cycles: got %0d want 31", bc); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL sll31_busy_in_done: got %b want 0", busy1); end
        step();
        checks++; if (done1 !== 1'b0 || r !== res1) begin
            errors++; $display("FAIL done_one_cycle: got done=%b res=%h want 0 80000000", done1, res1);
        end
        settle();
    endtask

    task automatic test_sra_srl();
        int lat, bc;
        logic [31:0] r;
        runOp(1'b0, 2'd2, 5'd4, 32'hF000_0000, lat, bc, r);
        checks++; if (r !== 32'hFF00_0000) begin errors++; $display("FAIL sra4_res: got %h want FF000000", r); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL sra4_latency: got %0d want 5", lat); end
        settle();
        runOp(1'b0, 2'd1, 5'd4, 32'hF000_0000, lat, bc, r);
        checks++; if (r !== 32'h0F00_0000) begin errors++; $display("FAIL srl4_res: got %h want 0F000000", r); end
        settle();
        runOp(1'b1, 2'd2, 5'd8, 32'h8000_0000, lat, bc, r);
        checks++; if (r !== 32'hFF80_0000 || lat !== 3) begin
            errors++; $display("FAIL sra8_step4: got res=%h lat=%0d want FF800000 3", r, lat);
        end
        settle();
    endtask

    task automatic test_rotr();
        int lat, bc;
        logic [31:0] r;
        runOp(1'b0, 2'd3, 5'd4, 32'h0000_00F1, lat, bc, r);
        checks++; if (r !== 32'h1000_000F) begin errors++; $display("FAIL rotr4_res: got %h want 1000000F", r); end
        settle();
        runOp(1'b1, 2'd3, 5'd4, 32'h0000_00F1, lat, bc, r);
        checks++; if (r !== 32'h1000_000F || lat !== 2) begin
            errors++; $display("FAIL rotr4_step4: got res=%h lat=%0d want 1000000F 2", r, lat);
        end
        settle();
        runOp(1'b1, 2'd3, 5'd5, 32'h0000_00F1, lat, bc, r);
        checks++; if (r !== 32'h8800_0007 || lat !== 3) begin
            errors++; $display("FAIL rotr5_step4: got res=%h lat=%0d want 88000007 3", r, lat);
        end
        settle();
    endtask

    task automatic test_sa_zero();
        int lat, bc;
        logic [31:0] r;
        for (int op = 0; op < 4; op++) begin
            runOp(1'b0, op[1:0], 5'd0, 32'hDEAD_BEEF, lat, bc, r);
            checks++; if (r !== 32'hDEAD_BEEF || lat !== 1 || bc !== 0) begin
                errors++; $display("FAIL sa0_op%0d: got res=%h lat=%0d busy=%0d want DEADBEEF 1 0", op, r, lat, bc);
            end
            settle();
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, n;
        logic [31:0] r;
        runOp(1'b0, 2'd0, 5'd2, 32'h0000_0001, lat, bc, r);
        checks++; if (r !== 32'h0000_0004 || lat !== 3) begin
            errors++; $display("FAIL b2b_first: got res=%h lat=%0d want 00000004 3", r, lat);
        end
        // Request issued from DONE must go straight to SHIFT.
        opShift = 2'd1; sa = 5'd3; b = 32'h0000_0080; start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (busy1 !== 1'b1 || done1 !== 1'b0 || res1 !== 32'h0000_0004) begin
            errors++; $display("FAIL b2b_no_gap: got busy=%b done=%b res=%h want 1 0 00000004", busy1, done1, res1);
        end
        opShift = 2'd0; sa = 5'd1; b = 32'hFFFF_FFFF; start = 1'b1;
        step();
        start = 1'b0;
        n = -1;
        for (int k = 0; k < 20; k++) begin
            if (done1) begin
                n = k;
                break;
            end
            step();
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL b2b_second_latency: got %0d want 2", n); end
        checks++; if (res1 !== 32'h0000_0010) begin errors++; $display("FAIL b2b_second_res: got %h want 00000010", res1); end
        step();
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++; $display("FAIL ignored_start_queued: got busy=%b done=%b want 0 0", busy1, done1);
        end
        settle();
    endtask

    task automatic test_flush();
        int dones;
        opShift = 2'd0; sa = 5'd10; b = 32'h0000_0001; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || res1 !== 32'h0000_0010) begin
            errors++; $display("FAIL flush_shift: got busy=%b done=%b res=%h want 0 0 00000010", busy1, done1, res1);
        end
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (done1 || busy1) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL flush_no_done: got %0d activity cycles want 0", dones); end
        opShift = 2'd1; sa = 5'd0; b = 32'h1234_5678; start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || res1 !== 32'h0000_0010) begin
            errors++; $display("FAIL flush_start_idle: got busy=%b done=%b res=%h want 0 0 00000010", busy1, done1, res1);
        end
        settle();
    endtask

    task automatic test_async_reset();
        opShift = 2'd0; sa = 5'd20; b = 32'h0000_0003; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        checks++; if (busy1 !== 1'b1 || res1 !== 32'h0000_0010) begin
            errors++; $display("FAIL res_hold_in_shift: got busy=%b res=%h want 1 00000010", busy1, res1);
        end
        #2;
        rstN = 1'b0;
        #1;
        checks++; if (res1 !== 32'h0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++; $display("FAIL async_reset: got res=%h busy=%b done=%b want 0 0 0", res1, busy1, done1);
        end
        @(negedge clk);
        rstN = 1'b1;
        step();
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || res1 !== 32'h0) begin
            errors++; $display("FAIL after_reset_idle: got busy=%b done=%b res=%h want 0 0 0", busy1, done1, res1);
        end
    endtask

    initial begin
        rstN = 1'b0; start = 1'b0; flush = 1'b0;
        opShift = 2'd0; sa = 5'd0; b = 32'h0;
        #12;
        test_reset();
        @(negedge clk);
        rstN = 1'b1;
        step();
        test_sll();
        test_sra_srl();
        test_rotr();
        test_sa_zero();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
